// File: rtl/fetch_pkg.sv
// Shared definitions for the RV32I fetch stage: the NOP filler word,
// the FSM state encoding and the default reset PC.
package fetch_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FLUSH
    } fetch_state_e;

    // Fetch addresses are always word aligned; the byte offset is discarded.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with single-cycle flush; the head word is
// read combinationally, so a pushed entry becomes visible the next cycle.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the fetch PC, issues credit-limited word requests,
// buffers responses and presents {pc, inst} to decode; redirects flush wrong-path state.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   head_pc_q, head_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;

    logic [CW-1:0] fifo_count;
    logic [31:0]   fifo_head;
    logic [CW:0]   occupancy;
    logic          req_fire;
    logic          rsp_fire;
    logic          push;
    logic          pop;
    logic [31:0]   target_pc;

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (imem_rsp_data),
        .pop_i       (pop),
        .head_data_o (fifo_head),
        .count_o     (fifo_count)
    );

    // Every outstanding request owns a buffer slot, so responses can never overflow.
    always_comb begin
        occupancy      = {1'b0, inflight_q} + {1'b0, fifo_count};
        imem_req_valid = (state_q == FETCH) && !redirect_valid
                         && (occupancy < (CW+1)'(FIFO_DEPTH));
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_fire       = imem_rsp_valid && (inflight_q != '0);
        push           = rsp_fire && (state_q == FETCH) && !redirect_valid;
        dec_valid      = (fifo_count != '0) && (state_q == FETCH) && !redirect_valid;
        pop            = dec_valid && dec_ready;
        dec_inst       = (fifo_count != '0) ? fifo_head : NOP_INST;
        dec_pc         = head_pc_q;
        target_pc      = align_word(redirect_pc);
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                IDLE:    state_d = FETCH;
                FETCH:   state_d = FETCH;
                FLUSH:   state_d = (inflight_q == '0) ? FETCH : FLUSH;
                default: state_d = IDLE;
            endcase
        end
    end

    // Redirect overrides any PC advance in the same cycle.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);
        if (redirect_valid) begin
            fetch_pc_d = target_pc;
            head_pc_d  = target_pc;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                head_pc_d = head_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            inflight_q <= inflight_d;
        end
    end

endmodule
